// File: rtl/xlib_avalon_pkg.sv
// Shared types for the Avalon read arbiter: outstanding-burst tag and the
// burst-length decoder. The beats field is sized for burst-length fields of up
// to 8 bits (up to 256 beats), so one tag type serves every legal BL.
package xlib_avalon_pkg;

    localparam int unsigned TAG_ID_W    = 3;              // up to 8 requesters
    localparam int unsigned TAG_BEATS_W = 9;              // BL <= 8 -> 2**BL fits
    localparam int unsigned TAG_RLEN_W  = TAG_BEATS_W - 1;

    typedef struct packed {
        logic [TAG_ID_W-1:0]    id;
        logic [TAG_BEATS_W-1:0] beats;
    } rd_tag_t;

    // Burst length field to beat count; a zero field means 2**bl beats.
    function automatic logic [TAG_BEATS_W-1:0] rlen2beats(
        input logic [TAG_RLEN_W-1:0] rlen,
        input int unsigned           bl
    );
        if (rlen == '0) begin
            return TAG_BEATS_W'(1) << bl;
        end
        return {1'b0, rlen};
    endfunction

endpackage

// File: rtl/xlib_rd_tag_fifo.sv
// Outstanding-burst tag FIFO, depth 2**R_FW, show-ahead head.
// Ports: clk/rst (async active-high), push/tag_in write side, pop read side,
// head (current oldest tag), empty/full from a registered occupancy count.
// Push and pop in the same cycle are both honoured and leave the count unchanged.
module xlib_rd_tag_fifo
    import xlib_avalon_pkg::*;
#(
    parameter int unsigned R_FW = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  rd_tag_t tag_in,
    input  logic    pop,
    output rd_tag_t head,
    output logic    empty,
    output logic    full
);

    localparam int unsigned DEPTH = 1 << R_FW;
    localparam int unsigned CNT_W = R_FW + 1;

    rd_tag_t          mem [DEPTH];
    logic [R_FW-1:0]  wptr;
    logic [R_FW-1:0]  rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= tag_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + R_FW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + R_FW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xlib_avalon_rd_arb.sv
// Shares one Avalon burst read master between NR requesters. Requests are
// arbitrated round-robin (or fixed priority, requester 0 highest, when
// XLIB_RD_ARB_FIXED_PRIO_EN is defined), each accepted burst is tagged in a
// FIFO, and returned beats are steered back to the owner in order.
// Ports:
//   clk, rst                 clock, async active-high reset
//   s_rval/s_rrdy            per-requester request handshake
//   s_rlen/s_raddr           per-requester burst length / start address
//   s_rdata/s_rdval          returned data (broadcast) / one-hot owner valid
//   m_rval/m_rrdy            master request handshake
//   m_rlen/m_raddr           master burst length / address
//   m_rdata/m_rdval          master read data / valid
//   err                      sticky: beat arrived with no outstanding burst
module xlib_avalon_rd_arb
    import xlib_avalon_pkg::*;
#(
    parameter int unsigned NR   = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned BL   = 4,
    parameter int unsigned R_FW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [NR-1:0]          s_rrdy,
    input  logic [NR-1:0]          s_rval,
    input  logic [NR-1:0][BL-1:0]  s_rlen,
    input  logic [NR-1:0][AW-1:0]  s_raddr,
    output logic [NR-1:0][DW-1:0]  s_rdata,
    output logic [NR-1:0]          s_rdval,
    input  logic                   m_rrdy,
    output logic                   m_rval,
    output logic [BL-1:0]          m_rlen,
    output logic [AW-1:0]          m_raddr,
    input  logic [DW-1:0]          m_rdata,
    input  logic                   m_rdval,
    output logic                   err
);

    localparam int unsigned CW = BL + 1;

    logic [2:0]    g;
    logic [2:0]    g_hi;
    logic [2:0]    g_lo;
    logic          hi_found;
    logic [2:0]    rr_start;
    logic [2:0]    lock_g;
    logic          lock;
    logic          req_ok;
    logic          accept;
    logic          tag_full;
    logic          tag_empty;
    rd_tag_t       head;
    rd_tag_t       push_tag;
    logic          pop;
    logic [CW-1:0] cnt;
    logic [CW-1:0] eff_cnt;
    logic [CW-1:0] rem;
    logic          own_valid;
    logic          beat_ok;

    // Rotating priority: lowest requesting index at or above rr_start wins,
    // otherwise the lowest requesting index overall (wrap-around).
    always_comb begin
        g_hi     = '0;
        g_lo     = '0;
        hi_found = 1'b0;
        for (int i = int'(NR) - 1; i >= 0; i--) begin
            if (s_rval[i]) begin
                g_lo = 3'(i);
                if (3'(i) >= rr_start) begin
                    g_hi     = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        g = lock ? lock_g : (hi_found ? g_hi : g_lo);
    end

    assign req_ok = ~tag_full & ~rst;
    assign m_rval = (|s_rval) & req_ok;
    assign accept = m_rval & m_rrdy;

    // Request mux toward the master and grant back to the selected requester.
    always_comb begin
        m_raddr = '0;
        m_rlen  = '0;
        s_rrdy  = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (g == 3'(i)) begin
                m_raddr   = s_raddr[i];
                m_rlen    = s_rlen[i];
                s_rrdy[i] = m_rrdy & req_ok;
            end
        end
    end

    assign push_tag.id    = g;
    assign push_tag.beats = rlen2beats(TAG_RLEN_W'(m_rlen), BL);

`ifdef XLIB_RD_ARB_FIXED_PRIO_EN
    assign rr_start = '0;
`else
    logic [2:0] rr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else if (accept) begin
            rr_q <= (g == 3'(NR - 1)) ? 3'd0 : g + 3'd1;
        end
    end

    assign rr_start = rr_q;
`endif

    // Hold the grant while the master stalls so the presented request is stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock   <= 1'b0;
            lock_g <= '0;
        end else if (accept) begin
            lock <= 1'b0;
        end else if (m_rval) begin
            lock   <= 1'b1;
            lock_g <= g;
        end
    end

    xlib_rd_tag_fifo #(
        .R_FW (R_FW)
    ) u_tag_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (accept),
        .tag_in (push_tag),
        .pop    (pop),
        .head   (head),
        .empty  (tag_empty),
        .full   (tag_full)
    );

    // cnt==0 means the head tag is not yet loaded; a beat then uses the head
    // length directly, so back-to-back bursts return without a bubble.
    assign own_valid = (cnt != '0) | ~tag_empty;
    assign eff_cnt   = (cnt != '0) ? cnt : CW'(head.beats);
    assign rem       = eff_cnt - CW'(1);
    assign beat_ok   = m_rdval & own_valid & ~rst;
    assign pop       = beat_ok & (rem == '0);

    always_comb begin
        for (int i = 0; i < int'(NR); i++) begin
            s_rdata[i] = m_rdata;
            s_rdval[i] = beat_ok & (head.id == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (beat_ok) begin
            cnt <= rem;
        end else if ((cnt == '0) && !tag_empty) begin
            cnt <= CW'(head.beats);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (m_rdval && !own_valid) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xlib_avalon_rd_arb.sv
// Bench for xlib_avalon_rd_arb (NR=2, BL=4, tag FIFO depth 4).
// A queue-level reference of outstanding bursts predicts every output each cycle.
module tb_xlib_avalon_rd_arb;

    localparam int NR   = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BL   = 4;
    localparam int R_FW = 2;
    localparam int DEPTH = 4;

    logic                  clk;
    logic                  rst;
    logic [NR-1:0]         s_rrdy;
    logic [NR-1:0]         s_rval;
    logic [NR-1:0][BL-1:0] s_rlen;
    logic [NR-1:0][AW-1:0] s_raddr;
    logic [NR-1:0][DW-1:0] s_rdata;
    logic [NR-1:0]         s_rdval;
    logic                  m_rrdy;
    logic                  m_rval;
    logic [BL-1:0]         m_rlen;
    logic [AW-1:0]         m_raddr;
    logic [DW-1:0]         m_rdata;
    logic                  m_rdval;
    logic                  err;

    xlib_avalon_rd_arb #(
        .NR(NR), .AW(AW), .DW(DW), .BL(BL), .R_FW(R_FW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_rrdy(s_rrdy), .s_rval(s_rval), .s_rlen(s_rlen), .s_raddr(s_raddr),
        .s_rdata(s_rdata), .s_rdval(s_rdval),
        .m_rrdy(m_rrdy), .m_rval(m_rval), .m_rlen(m_rlen), .m_raddr(m_raddr),
        .m_rdata(m_rdata), .m_rdval(m_rdval), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: outstanding bursts as (owner, beats left) queues.
    int mq_id[$];
    int mq_beats[$];
    int ref_rr;
    bit ref_lock;
    int ref_lock_id;
    bit ref_err;

    int checks;
    int failures;
    int acc_log[$];
    int beat_log[$];
    int pulses[NR];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic compare_and_step();
        int            g;
        int            idx;
        bit            any;
        bit            full;
        bit            exp_mrval;
        logic [NR-1:0] exp_rrdy;
        logic [NR-1:0] exp_rdval;
        int            blen;

        any  = |s_rval;
        full = (mq_id.size() == DEPTH);
        g    = -1;
        if (ref_lock) begin
            g = ref_lock_id;
        end else begin
            for (int k = 0; k < NR; k++) begin
                idx = (ref_rr + k) % NR;
                if (g < 0 && s_rval[idx]) g = idx;
            end
        end
        exp_mrval = any && !full && !rst;

        chk("m_rval", m_rval, exp_mrval);
        if (exp_mrval) begin
            exp_rrdy = '0;
            for (int i = 0; i < NR; i++) begin
                if (i == g) begin
                    chk("m_raddr", m_raddr, s_raddr[i]);
                    chk("m_rlen", m_rlen, s_rlen[i]);
                    exp_rrdy[i] = m_rrdy;
                end
            end
            chk("s_rrdy", s_rrdy, exp_rrdy);
        end else if (any || rst) begin
            chk("s_rrdy_idle", s_rrdy, '0);
        end

        exp_rdval = '0;
        if (!rst && m_rdval && mq_id.size() > 0) begin
            for (int i = 0; i < NR; i++) if (i == mq_id[0]) exp_rdval[i] = 1'b1;
        end
        chk("s_rdval", s_rdval, exp_rdval);
        if (exp_rdval != '0) begin
            for (int i = 0; i < NR; i++) chk("s_rdata", s_rdata[i], m_rdata);
        end
        chk("err", err, rst ? 1'b0 : ref_err);

        // Observations for the directed literal checks.
        for (int i = 0; i < NR; i++) begin
            if (m_rval && m_rrdy && s_rrdy[i]) acc_log.push_back(i);
            if (s_rdval[i]) begin
                beat_log.push_back(i);
                pulses[i]++;
            end
        end

        // Advance the reference to the coming clock edge.
        if (rst) begin
            mq_id.delete();
            mq_beats.delete();
            ref_rr   = 0;
            ref_lock = 0;
            ref_err  = 0;
        end else begin
            if (m_rdval) begin
                if (mq_id.size() == 0) begin
                    ref_err = 1;
                end else begin
                    mq_beats[0] = mq_beats[0] - 1;
                    if (mq_beats[0] == 0) begin
                        void'(mq_id.pop_front());
                        void'(mq_beats.pop_front());
                    end
                end
            end
            if (exp_mrval && m_rrdy) begin
                blen = 0;
                for (int i = 0; i < NR; i++) if (i == g) blen = int'(s_rlen[i]);
                mq_id.push_back(g);
                mq_beats.push_back(blen == 0 ? (1 << BL) : blen);
                ref_rr   = (g + 1) % NR;
                ref_lock = 0;
            end else if (exp_mrval) begin
                ref_lock    = 1;
                ref_lock_id = g;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compare_and_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic beats(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            m_rdval = 1'b1;
            m_rdata = DW'(base + i);
            tick(1);
        end
        m_rdval = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int exp_g[4];
        int exp_o[8];
        exp_g = '{0, 1, 0, 1};
        exp_o = '{0, 0, 0, 0, 1, 1, 1, 1};
        checks = 0;
        failures = 0;
        rst = 1'b1;
        s_rval = '0;
        s_rlen = '0;
        s_raddr = '0;
        m_rrdy = 1'b1;
        m_rdata = '0;
        m_rdval = 1'b0;
        ref_rr = 0; ref_lock = 0; ref_lock_id = 0; ref_err = 0;
        for (int i = 0; i < NR; i++) pulses[i] = 0;
        #1;
        do_reset();

        // Single requester, 8-beat burst.
        s_raddr[0] = 32'h1000; s_rlen[0] = 4'd8; s_rval = 2'b01;
        sample();
        chk("t1_m_rval", m_rval, 1'b1);
        chk("t1_m_raddr", m_raddr, 32'h1000);
        advance();
        s_rval = '0;
        pulses[0] = 0;
        beats(8, 32'hA000);
        tick(1);
        chk("t1_pulses0", pulses[0], 8);
        chk("t1_ref_empty", mq_id.size(), 0);

        // Contention, rr starting at 0.
        do_reset();
        acc_log.delete(); beat_log.delete();
        s_raddr[0] = 32'h2000; s_raddr[1] = 32'h3000;
        s_rlen[0] = 4'd4; s_rlen[1] = 4'd4; s_rval = 2'b11;
        tick(4);
        s_rval = '0;
        beats(16, 32'hB000);
        tick(1);
        for (int i = 0; i < 4; i++)
            chk("t2_grant", (acc_log.size() > i) ? acc_log[i] : -1, exp_g[i]);
        for (int i = 0; i < 8; i++)
            chk("t2_owner", (beat_log.size() > i) ? beat_log[i] : -1, exp_o[i]);

        // Lock: req1 stalled, req0 arrives later.
        acc_log.delete();
        s_raddr[1] = 32'h4000; s_rlen[1] = 4'd2;
        s_raddr[0] = 32'h5000; s_rlen[0] = 4'd3;
        s_rval = 2'b10; m_rrdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) s_rval = 2'b11;
            sample();
            chk("t3_lock_addr", m_raddr, 32'h4000);
            advance();
        end
        m_rrdy = 1'b1;
        sample();
        chk("t3_first_grant", s_rrdy, 2'b10);
        advance();
        s_rval = 2'b01;
        tick(1);
        s_rval = '0;
        beats(5, 32'hC000);
        tick(1);

        // Full FIFO blocks the fifth request until a burst retires.
        s_raddr[0] = 32'h7000; s_rlen[0] = 4'd2; s_rval = 2'b01;
        tick(4);
        sample();
        chk("t4_full_mrval", m_rval, 1'b0);
        chk("t4_full_rrdy", s_rrdy, 2'b00);
        advance();
        m_rdval = 1'b1; m_rdata = 32'hD000;
        tick(1);
        m_rdata = 32'hD001;
        sample();
        chk("t4_pop_still_blocked", m_rval, 1'b0);
        advance();
        m_rdval = 1'b0;
        sample();
        chk("t4_after_pop_mrval", m_rval, 1'b1);
        chk("t4_after_pop_rrdy", s_rrdy, 2'b01);
        advance();
        s_rval = '0;
        beats(8, 32'hD100);
        tick(1);

        // rlen=0 -> 16 beats, then a spurious beat.
        s_raddr[1] = 32'h8000; s_rlen[1] = 4'd0; s_rval = 2'b10;
        tick(1);
        s_rval = '0;
        pulses[1] = 0;
        beats(16, 32'hE000);
        chk("t5_pulses1", pulses[1], 16);
        chk("t5_err_before", err, 1'b0);
        beats(1, 32'hEEEE);
        tick(1);
        chk("t5_err_set", err, 1'b1);
        tick(3);
        chk("t5_err_sticky", err, 1'b1);

        // Reset mid-burst.
        do_reset();
        chk("t6_err_cleared", err, 1'b0);
        s_raddr[0] = 32'h9000; s_rlen[0] = 4'd8; s_rval = 2'b01;
        tick(1);
        s_rval = '0;
        beats(3, 32'hF000);
        rst = 1'b1; s_rval = 2'b01; m_rdval = 1'b1;
        sample();
        chk("t6_rst_mrval", m_rval, 1'b0);
        chk("t6_rst_rdval", s_rdval, 2'b00);
        chk("t6_rst_rrdy", s_rrdy, 2'b00);
        advance();
        rst = 1'b0; s_rval = '0;
        beats(5, 32'hF100);
        tick(1);
        chk("t6_err_after", err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xlib_avalon_rd_arb.md
Name: xlib_avalon_rd_arb

Overview:
- Shares one Avalon-style burst read master port (SDRAM side) between NR read requesters, e.g. dma_read source channel and map-table channel.
- Arbitrates burst requests round-robin and records each accepted burst in a tag FIFO.
- Routes the returned data beats back to the originating requester in order.
- Sits between the DMA read engines and xlib_avalon_ram / memory controller.

Parameters:
- NR, 2, number of read requesters (1..8)
- AW, 32, address width
- DW, 32, data width
- BL, 4, burst-length field width; beats = rlen, rlen==0 means 2**BL beats
- R_FW, 4, log2 depth of outstanding-burst tag FIFO

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s_rrdy  out  NR  per-requester request accept
- s_rval  in  NR  per-requester request valid
- s_rlen  in  NR x BL  per-requester burst length
- s_raddr  in  NR x AW  per-requester start address
- s_rdata  out  NR x DW  returned data (same word broadcast to all lanes)
- s_rdval  out  NR  returned data valid, one-hot to owner
- m_rrdy  in  1  master accepts request
- m_rval  out  1  master request valid
- m_rlen  out  BL  master burst length
- m_raddr  out  AW  master address
- m_rdata  in  DW  master read data
- m_rdval  in  1  master read data valid
- err  out  1  sticky: data beat with no outstanding tag

Behaviour:
- Reset: all of the following are cleared and held at 0 while rst=1: rr pointer (0), lock, tag FIFO, beat counter, err, m_rval, s_rrdy, s_rdval.
- Reset mid-burst discards outstanding tags; beats arriving after reset release raise err.
- Request side (combinational, zero latency):
  - m_rval = |s_rval & ~tag_full.
  - g = grant index. Round-robin search starts at rr pointer, selecting the first i with s_rval[i]=1.
  - m_raddr and m_rlen are muxed from g.
  - s_rrdy[g] = m_rrdy & ~tag_full; all other s_rrdy bits are 0.
- Accept = m_rval & m_rrdy. On accept:
  - push {id=g, beats} to the tag FIFO;
  - rr pointer <= (g+1) mod NR.
- Lock: if m_rval & ~m_rrdy, g is registered and held until accept, even if a higher-ranked requester raises s_rval (Avalon stability).
- A locked requester must keep s_rval, s_raddr and s_rlen stable.
- tag_full blocks new requests even if a pop occurs the same cycle.
- Return side:
  - beat counter cnt loads from the FIFO head when cnt==0 and FIFO is non-empty;
  - s_rdval[head.id] = m_rdval, zero latency;
  - s_rdata[*] = m_rdata;
  - each m_rdval decrements cnt;
  - the last beat pops the FIFO. The next head is usable on the following beat with no bubble; pop and load occur in the same cycle.
- A beat arriving in the same cycle as the accept of the first burst (FIFO empty) is an error, not a bypass: err <= 1 and no s_rdval is asserted.
- Simultaneous push and pop is allowed when not full; the count is unchanged.
- Count is R_FW+1 bits. Full when count == 2**R_FW.
- rlen==0 is loaded as 2**BL beats; the counter is BL+1 bits.

Optional Feature:
- Macro XLIB_RD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 highest, rr pointer removed. The lock rule still applies.
- Undefined: round-robin as above.

Decomposition:
- Package xlib_avalon_pkg holds:
  - typedef rd_tag_t {logic [2:0] id; logic [BL:0] beats};
  - function rlen2beats.
- Sub-module xlib_rd_tag_fifo: synchronous FIFO, depth 2**R_FW, registered count, same-cycle push/pop, no read latency (show-ahead head).

Test Plan:
- Single requester: s_rval[0] with raddr=0x1000, rlen=8, m_rrdy=1 -> m_rval=1 and m_raddr=0x1000 the same cycle; 8 m_rdval beats -> s_rdval[0] pulses 8 times, FIFO empty after.
- Contention: s_rval=2'b11 held, m_rrdy=1, rlen=4 each, rr=0 -> grant order 0,1,0,1; returned beats 0-3 go to req0, beats 4-7 go to req1.
- Lock: req1 requesting, m_rrdy=0 for 5 cycles, req0 asserts in cycle 2 -> m_raddr stays req1 address; first accept goes to req1.
- Full: R_FW=2, m_rdval=0, 4 bursts accepted -> 5th request sees s_rrdy=0 and m_rval=0; one burst fully returned -> 5th accepted the cycle after pop.
- rlen=0 -> 16 beats routed before pop; spurious m_rdval with empty FIFO -> err=1, sticky until rst.
- Reset asserted mid-burst after 3 of 8 beats -> all outputs 0 immediately; the 5 remaining beats after release set err=1.
